camera_world_transformer: RTL

CAMERA_WORLD_TRANSFORMER -- requirements
Module: camera_world_transformer

---
 rtl/math_pkg.sv | 29 ++
 rtl/vertex_pkg.sv | 24 ++
 rtl/rot_matrix_zyx.sv | 35 +++
 rtl/camera_world_transformer.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/math_pkg.sv
// Shared Q16.16 fixed-point types, constants and helpers.
package math_pkg;

    typedef logic signed [31:0] q16_16_t;

    typedef struct packed {
        q16_16_t x;
        q16_16_t y;
        q16_16_t z;
    } vec3_t;

    typedef struct packed {
        q16_16_t r11, r12, r13;
        q16_16_t r21, r22, r23;
        q16_16_t r31, r32, r33;
    } mat3_t;

    localparam q16_16_t Q_ONE = 32'sh0001_0000;
    localparam q16_16_t Q_MAX = 32'sh7FFF_FFFF;
    localparam q16_16_t Q_MIN = 32'sh8000_0000;

    // Q16.16 multiply: full 64-bit signed product, arithmetic >>>16, truncate.
    function automatic q16_16_t q_mul(input q16_16_t a, input q16_16_t b);
        logic signed [63:0] p;
        p = 64'(a) * 64'(b);
        return p[47:16];
    endfunction

endpackage

// File: rtl/vertex_pkg.sv
// Shared vertex, triangle and camera pose types.
package vertex_pkg;
    import math_pkg::*;

    typedef struct packed {
        vec3_t       pos;
        logic [31:0] color;
    } vertex_t;

    typedef struct packed {
        vertex_t v0;
        vertex_t v1;
        vertex_t v2;
    } triangle_t;

    // scale is carried for compatibility with other transformers; rigid here.
    typedef struct packed {
        vec3_t pos;
        vec3_t rot_sin;
        vec3_t rot_cos;
        vec3_t scale;
    } transform_t;

endpackage

// File: rtl/rot_matrix_zyx.sv
// Combinational R = Rz*Ry*Rx from per-axis sin/cos (Q16.16).
module rot_matrix_zyx
    import math_pkg::*;
(
    input  vec3_t   rot_sin,
    input  vec3_t   rot_cos,
    output q16_16_t r11, output q16_16_t r12, output q16_16_t r13,
    output q16_16_t r21, output q16_16_t r22, output q16_16_t r23,
    output q16_16_t r31, output q16_16_t r32, output q16_16_t r33
);
    q16_16_t sx, sy, sz, cx, cy, cz;
    q16_16_t czsy, szsy;

    assign sx = rot_sin.x;
    assign sy = rot_sin.y;
    assign sz = rot_sin.z;
    assign cx = rot_cos.x;
    assign cy = rot_cos.y;
    assign cz = rot_cos.z;

    // Shared partial products; each multiply truncates back to Q16.16.
    assign czsy = q_mul(cz, sy);
    assign szsy = q_mul(sz, sy);

    assign r11 = q_mul(cz, cy);
    assign r12 = q_mul(czsy, sx) - q_mul(sz, cx);
    assign r13 = q_mul(czsy, cx) + q_mul(sz, sx);
    assign r21 = q_mul(sz, cy);
    assign r22 = q_mul(szsy, sx) + q_mul(cz, cx);
    assign r23 = q_mul(szsy, cx) - q_mul(cz, sx);
    assign r31 = -sy;
    assign r32 = q_mul(cy, sx);
    assign r33 = q_mul(cy, cx);

endmodule

// File: rtl/camera_world_transformer.sv
// Camera-space triangle -> world-space: p_world = R*p_cam + C, one vertex per cycle.
// Optional macro CAM_WORLD_SAT_EN: saturate the final add instead of wrapping.
module camera_world_transformer
    import math_pkg::*;
    import vertex_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  transform_t transform,
    input  triangle_t  triangle,
    input  logic       in_valid,
    output logic       in_ready,
    output triangle_t  out_triangle,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, MATRIX, VERTEX, OUTPUT} state_e;

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic       init_q;
    triangle_t  tri_q, tri_d;
    vec3_t      pos_q, pos_d, sin_q, sin_d, cos_q, cos_d;
    vec3_t      c_q, c_d;
    mat3_t      r_q, r_d, r_comb;
    triangle_t  out_q, out_d;
    vec3_t      p_sel, w;
    logic       unused_scale;

    assign unused_scale = ^transform.scale;

    rot_matrix_zyx u_rot (
        .rot_sin (sin_q),
        .rot_cos (cos_q),
        .r11 (r_comb.r11), .r12 (r_comb.r12), .r13 (r_comb.r13),
        .r21 (r_comb.r21), .r22 (r_comb.r22), .r23 (r_comb.r23),
        .r31 (r_comb.r31), .r32 (r_comb.r32), .r33 (r_comb.r33)
    );

    // One output component: wide dot product, single >>>16, then add C.
    function automatic q16_16_t world_comp(input q16_16_t ra, input q16_16_t rb,
                                           input q16_16_t rc, input vec3_t p,
                                           input q16_16_t c);
        logic signed [65:0] acc;
        logic signed [65:0] sum;
        acc = 66'(64'(ra) * 64'(p.x)) + 66'(64'(rb) * 64'(p.y)) + 66'(64'(rc) * 64'(p.z));
        sum = (acc >>> 16) + 66'(c);
`ifdef CAM_WORLD_SAT_EN
        if (sum > 66'(Q_MAX)) return Q_MAX;
        if (sum < 66'(Q_MIN)) return Q_MIN;
`endif
        return sum[31:0];
    endfunction

    // Select the vertex being processed and compute its world position.
    always_comb begin
        p_sel = tri_q.v0.pos;
        case (idx_q)
            2'd1:    p_sel = tri_q.v1.pos;
            2'd2:    p_sel = tri_q.v2.pos;
            default: p_sel = tri_q.v0.pos;
        endcase
        w.x = world_comp(r_q.r11, r_q.r12, r_q.r13, p_sel, c_q.x);
        w.y = world_comp(r_q.r21, r_q.r22, r_q.r23, p_sel, c_q.y);
        w.z = world_comp(r_q.r31, r_q.r32, r_q.r33, p_sel, c_q.z);
    end

    // FSM next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tri_d     = tri_q;
        pos_d     = pos_q;
        sin_d     = sin_q;
        cos_d     = cos_q;
        c_d       = c_q;
        r_d       = r_q;
        out_d     = out_q;
        in_ready  = init_q && (state_q == IDLE);
        out_valid = (state_q == OUTPUT);
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    tri_d   = triangle;
                    pos_d   = transform.pos;
                    sin_d   = transform.rot_sin;
                    cos_d   = transform.rot_cos;
                    state_d = MATRIX;
                end
            end
            MATRIX: begin
                r_d     = r_comb;
                c_d     = pos_q;
                idx_d   = 2'd0;
                state_d = VERTEX;
            end
            VERTEX: begin
                idx_d = idx_q + 2'd1;
                case (idx_q)
                    2'd0: out_d.v0 = '{pos: w, color: tri_q.v0.color};
                    2'd1: out_d.v1 = '{pos: w, color: tri_q.v1.color};
                    default: begin
                        out_d.v2 = '{pos: w, color: tri_q.v2.color};
                        idx_d    = 2'd0;
                        state_d  = OUTPUT;
                    end
                endcase
            end
            OUTPUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            init_q  <= 1'b0;
            tri_q   <= '0;
            pos_q   <= '0;
            sin_q   <= '0;
            cos_q   <= '0;
            c_q     <= '0;
            r_q     <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            init_q  <= 1'b1;
            tri_q   <= tri_d;
            pos_q   <= pos_d;
            sin_q   <= sin_d;
            cos_q   <= cos_d;
            c_q     <= c_d;
            r_q     <= r_d;
            out_q   <= out_d;
        end
    end

    assign out_triangle = out_q;

endmodule
